blink_seq_monitor: RTL and testbench

//  Receive-side checker for the 3-lamp turn-signal pattern {L,M,R}. It observes the lamp lines driven
//  by the turn-signal FSM and verifies the thermometer sequence 000->001->011->111->000. It reports the

---
 rtl/blink_seq_monitor.sv | 119 +++++++++++
 tb/tb_blink_seq_monitor.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_seq_monitor.sv
// Receive-side checker for the 3-lamp thermometer turn-signal pattern 000->001->011->111->000.
// Reports the current phase, completed cycles and classified protocol violations.
module blink_seq_monitor #(
  parameter int HOLD_MAX = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L,
  input  logic             M,
  input  logic             R,
  input  logic             clr,
  output logic             busy,
  output logic [1:0]       phase,
  output logic             done,
  output logic             err,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycles
);
  typedef enum logic [2:0] {IDLE, P1, P2, P3, RESYNC} state_t;

  localparam int               HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]    HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, next_state, adv_state;
  logic [2:0]       lmr_q, hold_pat, adv_pat;
  logic [HW-1:0]    hold_cnt, next_hold;
  logic [1:0]       cause;
  logic             cycle_done, illegal;
  logic             busy_d, done_d, err_d, sticky_d;
  logic [1:0]       phase_d, code_d;
  logic [CNT_W-1:0] cycles_d;

  // Input stage, FSM state and all outputs are registered on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lmr_q      <= 3'b000;
      state      <= IDLE;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      phase      <= 2'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_code   <= 2'd0;
      cycles     <= '0;
    end else begin
      lmr_q      <= {L, M, R};
      state      <= next_state;
      hold_cnt   <= next_hold;
      busy       <= busy_d;
      phase      <= phase_d;
      done       <= done_d;
      err        <= err_d;
      err_sticky <= sticky_d;
      err_code   <= code_d;
      cycles     <= cycles_d;
    end
  end

  // Each active state has one pattern it may hold and one it may advance to.
  always_comb begin
    next_state = state;
    next_hold  = hold_cnt;
    cause      = 2'd0;
    cycle_done = 1'b0;
    hold_pat   = 3'b000;
    adv_pat    = 3'b001;
    adv_state  = P1;
    illegal    = (lmr_q == 3'b010) || (lmr_q == 3'b100) ||
                 (lmr_q == 3'b101) || (lmr_q == 3'b110);
    case (state)
      P1: begin hold_pat = 3'b001; adv_pat = 3'b011; adv_state = P2; end
      P2: begin hold_pat = 3'b011; adv_pat = 3'b111; adv_state = P3; end
      P3: begin hold_pat = 3'b111; adv_pat = 3'b000; adv_state = IDLE; end
      default: ;
    endcase
    if (state == RESYNC) begin
      if (lmr_q == 3'b000) next_state = IDLE;
    end else if (illegal) begin
      cause = 2'd1;
    end else if (lmr_q == adv_pat) begin
      next_state = adv_state;
      next_hold  = HW'(1);
      cycle_done = (state == P3);
    end else if (lmr_q == hold_pat) begin
      if (state != IDLE) begin
        if (hold_cnt >= HOLD_LIM) cause = 2'd3;
        else next_hold = hold_cnt + HW'(1);
      end
    end else begin
      cause = 2'd2;
    end
    if (cause != 2'd0) next_state = RESYNC;
  end

  // clr clears first so a coincident done or err still lands in the new values.
  always_comb begin
    busy_d = (next_state == P1) || (next_state == P2) || (next_state == P3);
    case (next_state)
      P1:      phase_d = 2'd1;
      P2:      phase_d = 2'd2;
      P3:      phase_d = 2'd3;
      default: phase_d = 2'd0;
    endcase
    done_d   = cycle_done;
    err_d    = (cause != 2'd0);
    cycles_d = clr ? '0 : cycles;
    if (cycle_done && (cycles_d != CNT_MAX)) cycles_d = cycles_d + CNT_W'(1);
    sticky_d = clr ? 1'b0 : err_sticky;
    code_d   = clr ? 2'd0 : err_code;
    if (err_d) begin
      sticky_d = 1'b1;
      code_d   = cause;
    end
  end
endmodule

// File: tb/tb_blink_seq_monitor.sv
// Self-checking bench: three monitor variants share one lamp stimulus and are compared
// every cycle against a sequence-index reference model, plus directed scenario checks.
module tb_blink_seq_monitor;
  logic clk = 1'b0;
  logic reset, L, M, R, clr;

  logic       busy_a, done_a, err_a, sticky_a;
  logic       busy_b, done_b, err_b, sticky_b;
  logic       busy_c, done_c, err_c, sticky_c;
  logic [1:0] phase_a, code_a, phase_b, code_b, phase_c, code_c;
  logic [7:0] cyc_a, cyc_b;
  logic [1:0] cyc_c;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: position in the legal sequence (-1 = resyncing)
  int       SEQ [4] = '{0, 1, 3, 7};
  int       HMAX[3] = '{1, 3, 1};
  int       CMAX[3] = '{255, 255, 3};
  int       m_pos [3];
  int       m_hold[3];
  logic [2:0] m_lmrq;
  bit       e_done[3], e_err[3], e_sticky[3];
  int       e_code[3], e_cyc[3];

  always #5 clk = ~clk;

  blink_seq_monitor #(.HOLD_MAX(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .L(L), .M(M), .R(R), .clr(clr),
    .busy(busy_a), .phase(phase_a), .done(done_a), .err(err_a),
    .err_sticky(sticky_a), .err_code(code_a), .cycles(cyc_a));

  blink_seq_monitor #(.HOLD_MAX(3), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .L(L), .M(M), .R(R), .clr(clr),
    .busy(busy_b), .phase(phase_b), .done(done_b), .err(err_b),
    .err_sticky(sticky_b), .err_code(code_b), .cycles(cyc_b));

  blink_seq_monitor #(.HOLD_MAX(1), .CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .L(L), .M(M), .R(R), .clr(clr),
    .busy(busy_c), .phase(phase_c), .done(done_c), .err(err_c),
    .err_sticky(sticky_c), .err_code(code_c), .cycles(cyc_c));

  function automatic logic [15:0] obs(int k);
    case (k)
      0:       return {busy_a, phase_a, done_a, err_a, sticky_a, code_a, cyc_a};
      1:       return {busy_b, phase_b, done_b, err_b, sticky_b, code_b, cyc_b};
      default: return {busy_c, phase_c, done_c, err_c, sticky_c, code_c, 6'd0, cyc_c};
    endcase
  endfunction

  function automatic logic [15:0] expv(int k);
    logic [1:0] ph;
    ph = (m_pos[k] > 0) ? 2'(m_pos[k]) : 2'd0;
    return {m_pos[k] > 0, ph, e_done[k], e_err[k], e_sticky[k], 2'(e_code[k]), 8'(e_cyc[k])};
  endfunction

  function automatic int seq_index(input logic [2:0] p);
    for (int i = 0; i < 4; i++) if (p == 3'(SEQ[i])) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 0; m_hold[k] = 0; e_done[k] = 0; e_err[k] = 0;
      e_sticky[k] = 0; e_code[k] = 0; e_cyc[k] = 0;
    end
    m_lmrq = 3'b000;
  endtask

  // One clock of the model: judge the previously sampled lamps against the sequence
  task automatic model_step();
    int idx, nxt, cause;
    idx = seq_index(m_lmrq);
    for (int k = 0; k < 3; k++) begin
      e_done[k] = 0; e_err[k] = 0; cause = 0;
      if (clr) begin e_cyc[k] = 0; e_sticky[k] = 0; e_code[k] = 0; end
      nxt = (m_pos[k] + 1) % 4;
      if (m_pos[k] < 0) begin
        if (m_lmrq == 3'b000) m_pos[k] = 0;
      end else if (idx < 0) begin
        cause = 1;
      end else if (idx == m_pos[k]) begin
        if (idx != 0) begin
          if (m_hold[k] + 1 > HMAX[k]) cause = 3;
          else m_hold[k]++;
        end
      end else if (idx == nxt) begin
        if (idx == 0) begin
          e_done[k] = 1;
          if (e_cyc[k] < CMAX[k]) e_cyc[k]++;
        end
        m_pos[k] = idx; m_hold[k] = 1;
      end else begin
        cause = 2;
      end
      if (cause != 0) begin
        e_err[k] = 1; e_sticky[k] = 1; e_code[k] = cause; m_pos[k] = -1;
      end
    end
    m_lmrq = {L, M, R};
  endtask

  task automatic drive(input logic [2:0] p, input logic c);
    {L, M, R} = p;
    clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(3'b000, 1'b0);
    #1 reset = 1'b1;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== 16'h0) $display("[TB] FAIL reset_async inst%0d: got %h expected %h", k, obs(k), 16'h0);
      else n_pass++;
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL reset_idle inst%0d: got %h expected %h", k, obs(k), expv(k));
        else n_pass++;
      end
    end
  endtask

  task automatic test_legal_cycle();
    logic [2:0] pats[7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    int ph_seq[$];
    int done_step, err_cnt, ph_code;
    done_step = -1; err_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      drive(pats[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL legal_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (phase_a != 2'd0 && (ph_seq.size() == 0 || ph_seq[$] != int'(phase_a))) ph_seq.push_back(int'(phase_a));
      if (done_a) done_step = i;
      if (err_a) err_cnt++;
    end
    ph_code = (ph_seq.size() == 3) ? ph_seq[0] * 100 + ph_seq[1] * 10 + ph_seq[2] : -1;
    n_checks++;
    if (ph_code !== 123) $display("[TB] FAIL legal_phase_order: got %0d expected 123", ph_code);
    else n_pass++;
    n_checks++;
    if (done_step !== 5) $display("[TB] FAIL legal_done_step: got %0d expected 5", done_step);
    else n_pass++;
    n_checks++;
    if (cyc_a !== 8'd1 || err_cnt !== 0) $display("[TB] FAIL legal_count: got cycles=%0d errs=%0d expected cycles=1 errs=0", cyc_a, err_cnt);
    else n_pass++;
  endtask

  task automatic test_order_error();
    logic [2:0] pats[12] = '{3'b001, 3'b111, 3'b011, 3'b011, 3'b000, 3'b000,
                             3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    int err_cnt, done_cnt;
    err_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(pats[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL order_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (err_a) err_cnt++;
      if (done_a) done_cnt++;
    end
    n_checks++;
    if (err_cnt !== 1 || code_a !== 2'd2 || sticky_a !== 1'b1)
      $display("[TB] FAIL order_err: got errs=%0d code=%0d sticky=%0b expected errs=1 code=2 sticky=1", err_cnt, code_a, sticky_a);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("[TB] FAIL order_recover_done: got %0d expected 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [2:0] pats[9] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    int err_a_cnt, err_b_cnt, done_a_cnt, done_b_cnt;
    err_a_cnt = 0; err_b_cnt = 0; done_a_cnt = 0; done_b_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      drive(pats[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL hold_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (err_a) err_a_cnt++;
      if (err_b) err_b_cnt++;
      if (done_a) done_a_cnt++;
      if (done_b) done_b_cnt++;
    end
    n_checks++;
    if (err_a_cnt !== 1 || code_a !== 2'd3 || done_a_cnt !== 0)
      $display("[TB] FAIL hold_timeout_h1: got errs=%0d code=%0d dones=%0d expected errs=1 code=3 dones=0", err_a_cnt, code_a, done_a_cnt);
    else n_pass++;
    n_checks++;
    if (err_b_cnt !== 0 || done_b_cnt !== 1)
      $display("[TB] FAIL hold_ok_h3: got errs=%0d dones=%0d expected errs=0 dones=1", err_b_cnt, done_b_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal_clr();
    logic [2:0] pats[4] = '{3'b101, 3'b000, 3'b000, 3'b000};
    logic       clrs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(pats[i], clrs[i]);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL illegal_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (i == 1) begin
        n_checks++;
        if (err_a !== 1'b1 || code_a !== 2'd1) $display("[TB] FAIL illegal_code: got err=%0b code=%0d expected err=1 code=1", err_a, code_a);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (sticky_a !== 1'b0 || code_a !== 2'd0) $display("[TB] FAIL illegal_clr: got sticky=%0b code=%0d expected 0 0", sticky_a, code_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] pats[22];
    logic       clrs[22];
    int done_c_cnt;
    done_c_cnt = 0;
    for (int i = 0; i < 16; i++) begin pats[i] = 3'(SEQ[(i + 1) % 4]); clrs[i] = 1'b0; end
    pats[16] = 3'b001; pats[17] = 3'b011; pats[18] = 3'b111; pats[19] = 3'b000;
    pats[20] = 3'b000; pats[21] = 3'b000;
    for (int i = 16; i < 22; i++) clrs[i] = (i == 20);
    // The 4th done lands on step 16, before the clr cycle
    for (int i = 0; i < 22; i++) begin
      drive(pats[i], clrs[i]);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL b2b_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (done_c && i <= 16) done_c_cnt++;
      if (i == 16) begin
        n_checks++;
        if (cyc_c !== 2'd3 || done_c_cnt !== 4 || cyc_a !== 8'd4)
          $display("[TB] FAIL b2b_saturate: got c=%0d dones=%0d a=%0d expected c=3 dones=4 a=4", cyc_c, done_c_cnt, cyc_a);
        else n_pass++;
      end
      if (i == 20) begin
        n_checks++;
        if (cyc_c !== 2'd1 || cyc_a !== 8'd1 || done_c !== 1'b1)
          $display("[TB] FAIL b2b_clr_done: got c=%0d a=%0d done=%0b expected c=1 a=1 done=1", cyc_c, cyc_a, done_c);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pats[10] = '{3'b011, 3'b011, 3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    bit found;
    int done_cnt;
    logic [1:0] code_seen;
    found = 0; done_cnt = 0; code_seen = 2'd0;
    for (int w = 0; w < 8 && !found; w++) begin
      drive(3'(SEQ[(w + 1) % 4]), 1'b0);
      tick();
      if (phase_a == 2'd2) found = 1;
    end
    n_checks++;
    if (!found) $display("[TB] FAIL resetmid_reach_p2: got phase=%0d expected 2 within 8 cycles", phase_a);
    else n_pass++;
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== 16'h0) $display("[TB] FAIL resetmid_async inst%0d: got %h expected %h", k, obs(k), 16'h0);
      else n_pass++;
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(pats[i], 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL resetmid_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
      if (err_a) code_seen = code_a;
      if (done_a) done_cnt++;
    end
    n_checks++;
    if (code_seen !== 2'd2 || done_cnt !== 1)
      $display("[TB] FAIL resetmid_resync: got code=%0d dones=%0d expected code=2 dones=1", code_seen, done_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int gen, r;
    logic [2:0] p;
    gen = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin gen = (gen + 1) % 4; p = 3'(SEQ[gen]); end
      else if (r < 80) p = 3'(SEQ[gen]);
      else if (r < 92) p = 3'($urandom_range(0, 7));
      else begin gen = 0; p = 3'b000; end
      drive(p, $urandom_range(0, 19) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) $display("[TB] FAIL random_model inst%0d step%0d: got %h expected %h", k, i, obs(k), expv(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_order_error();
    test_hold();
    test_illegal_clr();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
